// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAM arbiter: FSM encoding, DRAM geometry and
// a helper that sizes saturating counters.
package dram_arbiter_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DBG = 1'b1
  } state_e;

  localparam int          DRAM_ADDR_W    = 14;
  localparam logic [31:0] DRAM_BASE_ADDR = 32'h4000;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear dominates increment.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < WIDTH'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dram_arbiter.sv
// Single-port DRAM arbiter: CPU MEM stage has priority, the debug port gets
// idle-cycle beats plus a bounded burst window once it has starved long enough.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int          ADDR_W     = DRAM_ADDR_W,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] BASE_ADDR  = DRAM_BASE_ADDR,
  parameter int          MAX_BURST  = 4,
  parameter int          STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_last,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo
);

  localparam int SW = cnt_width(STARVE_LIM);
  localparam int BW = cnt_width(MAX_BURST - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_cnt;
  logic [BW-1:0]     beat_cnt;
  logic              cpu_gnt;
  logic              enter_dbg;
  logic              burst_done;
  logic              starve_clr, starve_inc, beat_inc;
  logic [31:0]       cpu_off;
  logic [ADDR_W-1:0] cpu_word;
  logic              unused_addr_bits;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte address relative to the DRAM window; upper bits drop, so it wraps.
  assign cpu_off          = cpu_addr - BASE_ADDR;
  assign cpu_word         = cpu_off[ADDR_W+1:2];
  assign unused_addr_bits = ^{cpu_off[31:ADDR_W+2], cpu_off[1:0]};

  always_comb begin
    state_d    = state_q;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    cpu_stall  = 1'b0;
    enter_dbg  = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      S_CPU: begin
        cpu_gnt = cpu_req;
        dbg_gnt = ~cpu_req & dbg_req;
        // Denied cycle that would push the starvation count to its limit.
        if (cpu_req && dbg_req && (starve_cnt == SW'(STARVE_LIM - 1))) begin
          state_d   = S_DBG;
          enter_dbg = 1'b1;
        end
      end
      S_DBG: begin
        dbg_gnt    = dbg_req;
        cpu_stall  = cpu_req;
        burst_done = ~dbg_req | dbg_last | (beat_cnt == BW'(MAX_BURST - 1));
        if (burst_done) begin
          state_d = S_CPU;
        end
      end
      default: state_d = S_CPU;
    endcase
    if (rst) begin
      state_d    = S_CPU;
      cpu_gnt    = 1'b0;
      dbg_gnt    = 1'b0;
      cpu_stall  = 1'b0;
      enter_dbg  = 1'b0;
      burst_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  assign starve_clr = dbg_gnt | enter_dbg;
  assign starve_inc = dbg_req & ~dbg_gnt;
  assign beat_inc   = (state_q == S_DBG) & dbg_gnt & ~burst_done;

  sat_counter #(
    .WIDTH (SW),
    .LIMIT (STARVE_LIM)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .cnt_o (starve_cnt)
  );

  sat_counter #(
    .WIDTH (BW),
    .LIMIT (MAX_BURST - 1)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (enter_dbg),
    .inc_i (beat_inc),
    .cnt_o (beat_cnt)
  );

  assign mem_a     = dbg_gnt ? dbg_addr : cpu_word;
  assign mem_we    = cpu_gnt ? cpu_we : (dbg_gnt ? dbg_we : 1'b0);
  assign mem_d     = dbg_gnt ? dbg_wdata : cpu_wdata;
  assign cpu_rdata = mem_spo;

  assign rvalid_d = dbg_gnt & ~dbg_we;
  assign rdata_d  = rvalid_d ? mem_spo : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Reset cycles drop any read response still in flight.
  assign dbg_rvalid = rvalid_q & ~rst;
  assign dbg_rdata  = rst ? '0 : rdata_q;

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single-port 64 KB data DRAM between the CPU MEM stage and a debug/loader port. The CPU wins by default, so loads and stores keep zero-stall timing. The debug port gets opportunistic single beats in idle cycles and a bounded burst window once a starvation counter expires. The block sits between the MEM stage and `dram`, and its `cpu_stall` output is wired to the stop inputs of every pipeline register.

## Interface
Parameters:
- ADDR_W, 14: DRAM word-address width.
- DATA_W, 32: data width.
- BASE_ADDR, 32'h4000: CPU byte address that maps to DRAM word 0.
- MAX_BURST, 4: maximum number of debug beats per burst window (≥1).
- STARVE_LIM, 8: number of denied debug cycles that forces a burst window (≥1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  CPU clock (cpu_clk domain).
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM stage is accessing DRAM (load or store).
- cpu_we  in  1  store.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data.
- cpu_stall  out  1  freeze the whole pipeline this cycle.
- dbg_req  in  1  debug beat valid.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug word address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_last  in  1  final beat of the debug transfer.
- dbg_gnt  out  1  debug beat accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  registered debug read data.
- mem_a  out  ADDR_W  DRAM address.
- mem_we  out  1  DRAM write enable.
- mem_d  out  DATA_W  DRAM write data.
- mem_spo  in  DATA_W  DRAM asynchronous read data.

## Operation
- FSM has two states:
  - S_CPU: reset state; the CPU owns the port.
  - S_DBG: a debug burst window is open.
- S_CPU:
  - If `cpu_req`: CPU granted, `cpu_stall`=0, `dbg_gnt`=0.
  - Else if `dbg_req`: opportunistic debug beat, `dbg_gnt`=1.
- S_DBG:
  - `dbg_gnt`=`dbg_req`.
  - `cpu_stall`=`cpu_req`.
  - The CPU never touches the port.
- Starvation counter `starve_cnt` (saturating, 0..STARVE_LIM):
  - Increments on every cycle with `dbg_req` & ~`dbg_gnt`.
  - Clears on any `dbg_gnt` and on S_DBG entry.
- S_CPU→S_DBG at the edge where `starve_cnt` would become STARVE_LIM. `beat_cnt` clears on that entry.
- S_DBG→S_CPU at the edge of the first of:
  - a granted beat with `dbg_last`=1;
  - a granted beat with `beat_cnt`=MAX_BURST-1;
  - a cycle with `dbg_req`=0.
  - Otherwise `beat_cnt` increments on each granted beat.
- Address mux:
  - CPU: `mem_a` = (`cpu_addr` − BASE_ADDR)[ADDR_W+1:2]. Out-of-range addresses wrap modulo the DRAM size; no fault is raised.
  - Debug: `mem_a` = `dbg_addr`.
  - No grant: `mem_a` = CPU mapping.
- Write path: `mem_we` = granted requester's we, and 0 when nothing is granted. `mem_d` follows the granted requester.
- CPU read path: `cpu_rdata` = `mem_spo` (combinational), valid only in granted cycles.
- Debug read path: on a granted read beat, `dbg_rdata` <= `mem_spo`, and `dbg_rvalid`=1 for exactly the next cycle.

## Timing
- Reset values (while `rst`=1 and after release):
  - state S_CPU, `starve_cnt`=0, `beat_cnt`=0.
  - `dbg_rvalid`=0, `dbg_rdata`=0.
  - `dbg_gnt`=0, `cpu_stall`=0, `mem_we`=0 (forced combinationally during reset).
- CPU access: zero added latency when granted. A write commits at the granting edge.
- Debug read latency: 1 cycle from grant to `dbg_rvalid`. Back-to-back granted reads give a continuous `dbg_rvalid`.
- Worst-case CPU stall is MAX_BURST consecutive cycles. Worst-case debug wait is STARVE_LIM cycles; the grant comes in the following cycle.
- Simultaneous requests in S_CPU go to the CPU, except at the limit edge; the next cycle belongs to debug.
- Reset asserted mid-burst: the FSM returns to S_CPU on that edge. A pending `dbg_rvalid` is dropped, and the debug master must reissue.
- `cpu_stall` depends combinationally on `cpu_req` and state only. No path from `mem_spo` feeds back to stall.

## Structure
- Shared package holds:
  - the state encoding (S_CPU=1'b0, S_DBG=1'b1);
  - DRAM constants ADDR_W, BASE_ADDR.
- One sub-module, `sat_counter` (parameterised width/limit, clear/inc, sync active-high reset), instantiated twice: once for `starve_cnt`, once for `beat_cnt`.

## Test plan
- Reset with both requests high → `dbg_gnt`=0, `cpu_stall`=0, `mem_we`=0, `dbg_rvalid`=0. After release, the CPU is granted the first cycle.
- CPU writes 0xDEADBEEF at 0x4010, then reads 0x4010 next cycle, `dbg_req`=0 → `mem_a`=4, data returns same cycle, `cpu_stall` never asserts.
- CPU idle, debug reads word 4 → `dbg_gnt` same cycle, `dbg_rvalid`=1 with 0xDEADBEEF one cycle later, state stays S_CPU.
- `cpu_req` held high, `dbg_req` high, STARVE_LIM=8 → 8 denied cycles, then S_DBG. Debug beats 0..3 granted (MAX_BURST=4, `dbg_last`=0), `cpu_stall`=1 for exactly 4 cycles, then the CPU resumes.
- Forced burst with `dbg_last`=1 on the 2nd beat → `cpu_stall` lasts 2 cycles, `starve_cnt`=0 on return.
- `rst` pulsed on the 2nd beat of a forced burst → next cycle in S_CPU, `cpu_stall`=0, no `dbg_rvalid`.
